// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter sharing one external memory port between
// instruction fetch and load/store; one transaction in flight, fetch killable by flush.
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req_valid,
  output logic        o_if_req_ready,
  input  logic [31:0] i_if_req_a,
  input  logic        i_if_req_we,
  input  logic [3:0]  i_if_req_be,
  input  logic [31:0] i_if_req_d,
  output logic        o_if_resp_valid,
  input  logic        i_if_resp_ready,
  output logic [31:0] o_if_resp_data,
  input  logic        i_ls_req_valid,
  output logic        o_ls_req_ready,
  input  logic [31:0] i_ls_req_a,
  input  logic        i_ls_req_we,
  input  logic [3:0]  i_ls_req_be,
  input  logic [31:0] i_ls_req_d,
  output logic        o_ls_resp_valid,
  input  logic        i_ls_resp_ready,
  output logic [31:0] o_ls_resp_data,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_a,
  output logic        o_mem_req_we,
  output logic [3:0]  o_mem_req_be,
  output logic [31:0] o_mem_req_d,
  input  logic        i_mem_resp_valid,
  output logic        o_mem_resp_ready,
  input  logic [31:0] i_mem_resp_data,
  input  logic        i_flush
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  typedef enum logic {OWN_IF, OWN_LS} req_t;

  state_t      r_state;
  req_t        r_owner;
  req_t        r_last;
  logic        r_killed;
  logic        r_mem_valid;
  logic [68:0] r_payload;

  logic w_gnt_if;
  logic w_gnt_ls;
  logic w_owner_if;
  logic w_in_wait;
  logic w_kill;
  logic w_mem_resp_ready;

  always_comb begin
    w_owner_if = (r_owner == OWN_IF);
    w_in_wait  = (r_state == WAIT);
    w_kill     = i_flush & w_owner_if;
    // Fetch is masked by flush before the tie-break, so a flushed cycle with
    // both valid hands the grant to load/store regardless of last.
    w_gnt_if   = (r_state == IDLE) & i_if_req_valid & ~i_flush &
                 (~i_ls_req_valid | (r_last == OWN_LS));
    w_gnt_ls   = (r_state == IDLE) & i_ls_req_valid & ~w_gnt_if;
    w_mem_resp_ready = (r_state == DRAIN) |
                       (w_in_wait & (w_owner_if ? (i_if_resp_ready & ~i_flush)
                                                : i_ls_resp_ready));
  end

  // Readies are qualified by reset so every output is 0 while reset is held.
  assign o_if_req_ready   = w_gnt_if & i_rst_n;
  assign o_ls_req_ready   = w_gnt_ls & i_rst_n;
  assign o_if_resp_valid  = w_in_wait & w_owner_if & i_mem_resp_valid & ~i_flush;
  assign o_ls_resp_valid  = w_in_wait & ~w_owner_if & i_mem_resp_valid;
  assign o_if_resp_data   = (w_in_wait & w_owner_if)  ? i_mem_resp_data : '0;
  assign o_ls_resp_data   = (w_in_wait & ~w_owner_if) ? i_mem_resp_data : '0;
  assign o_mem_resp_ready = w_mem_resp_ready;
  assign o_mem_req_valid  = r_mem_valid;
  assign {o_mem_req_a, o_mem_req_we, o_mem_req_be, o_mem_req_d} = r_payload;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_last      <= OWN_IF;
      r_killed    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_payload   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_if | w_gnt_ls) begin
            r_payload   <= w_gnt_ls ? {i_ls_req_a, i_ls_req_we, i_ls_req_be, i_ls_req_d}
                                    : {i_if_req_a, i_if_req_we, i_if_req_be, i_if_req_d};
            r_owner     <= w_gnt_ls ? OWN_LS : OWN_IF;
            r_last      <= w_gnt_ls ? OWN_LS : OWN_IF;
            r_mem_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_req_ready) begin
            r_mem_valid <= 1'b0;
            r_killed    <= r_killed | w_kill;
            r_state     <= (r_killed | w_kill) ? DRAIN : WAIT;
          end else if (w_kill) begin
            r_killed <= 1'b1;
          end
        end
        WAIT: begin
          if (w_kill)
            r_state <= DRAIN;
          else if (i_mem_resp_valid & w_mem_resp_ready)
            r_state <= IDLE;
        end
        DRAIN: begin
          if (i_mem_resp_valid) begin
            r_killed <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, ISSUE stalls, flush kills
// in ISSUE/WAIT/IDLE, and asynchronous reset mid-transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_req_we;
  logic [31:0] if_req_a, if_req_d;
  logic [3:0]  if_req_be;
  logic        if_resp_valid, if_resp_ready;
  logic [31:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we;
  logic [31:0] ls_req_a, ls_req_d;
  logic [3:0]  ls_req_be;
  logic        ls_resp_valid, ls_resp_ready;
  logic [31:0] ls_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_a, mem_req_d;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        flush;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_if_req_valid  (if_req_valid),
    .o_if_req_ready  (if_req_ready),
    .i_if_req_a      (if_req_a),
    .i_if_req_we     (if_req_we),
    .i_if_req_be     (if_req_be),
    .i_if_req_d      (if_req_d),
    .o_if_resp_valid (if_resp_valid),
    .i_if_resp_ready (if_resp_ready),
    .o_if_resp_data  (if_resp_data),
    .i_ls_req_valid  (ls_req_valid),
    .o_ls_req_ready  (ls_req_ready),
    .i_ls_req_a      (ls_req_a),
    .i_ls_req_we     (ls_req_we),
    .i_ls_req_be     (ls_req_be),
    .i_ls_req_d      (ls_req_d),
    .o_ls_resp_valid (ls_resp_valid),
    .i_ls_resp_ready (ls_resp_ready),
    .o_ls_resp_data  (ls_resp_data),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_req_a     (mem_req_a),
    .o_mem_req_we    (mem_req_we),
    .o_mem_req_be    (mem_req_be),
    .o_mem_req_d     (mem_req_d),
    .i_mem_resp_valid(mem_resp_valid),
    .o_mem_resp_ready(mem_resp_ready),
    .i_mem_resp_data (mem_resp_data),
    .i_flush         (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; the non-granted requester (if valid) is left holding.
  task automatic run(input bit if_v, input bit ls_v, input bit exp_ls,
                     input logic [31:0] a_if, input logic [31:0] a_ls,
                     input logic ls_we, input logic [3:0] ls_be, input logic [31:0] ls_d,
                     input logic [31:0] rdata, input int unsigned issue_wait,
                     input int unsigned resp_wait, input bit flush_wait);
    logic [31:0] ea, ed;
    logic [4:0]  ewebe;
    if_req_valid = if_v; if_req_a = a_if; if_req_we = 1'b0; if_req_be = 4'hF; if_req_d = '0;
    ls_req_valid = ls_v; ls_req_a = a_ls; ls_req_we = ls_we; ls_req_be = ls_be; ls_req_d = ls_d;
    ea    = exp_ls ? a_ls : a_if;
    ed    = exp_ls ? ls_d : 32'h0;
    ewebe = exp_ls ? {ls_we, ls_be} : 5'h0F;
    #4;
    chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, !exp_ls});
    chk("ls_req_ready", {31'b0, ls_req_ready}, {31'b0, exp_ls});
    tick();
    if (exp_ls) ls_req_valid = 1'b0; else if_req_valid = 1'b0;
    for (int unsigned k = 0; k <= issue_wait; k++) begin
      mem_req_ready = (k == issue_wait);
      #4;
      chk("mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("mem_req_a", mem_req_a, ea);
      chk("mem_req_d", mem_req_d, ed);
      chk("mem_req_webe", {27'b0, mem_req_we, mem_req_be}, {27'b0, ewebe});
      chk("req_ready_busy", {30'b0, if_req_ready, ls_req_ready}, 32'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    flush = flush_wait;
    for (int unsigned k = 0; k < resp_wait; k++) begin
      #4;
      chk("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("wait_resp_valid", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    #4;
    chk("if_resp_valid", {31'b0, if_resp_valid}, {31'b0, !exp_ls});
    chk("ls_resp_valid", {31'b0, ls_resp_valid}, {31'b0, exp_ls});
    chk("resp_data", exp_ls ? ls_resp_data : if_resp_data, rdata);
    chk("mem_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
    tick();
    mem_resp_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Accept a fetch and advance it into WAIT with a zero-wait memory.
  task automatic fetch_to_wait(input logic [31:0] a);
    if_req_valid = 1'b1; if_req_a = a; if_req_we = 1'b0; if_req_be = 4'hF; if_req_d = '0;
    #4;
    chk("f2w_if_ready", {31'b0, if_req_ready}, 32'd1);
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    if_req_valid = 1'b0; if_req_a = '0; if_req_we = 1'b0; if_req_be = '0; if_req_d = '0;
    ls_req_valid = 1'b0; ls_req_a = '0; ls_req_we = 1'b0; ls_req_be = '0; ls_req_d = '0;
    if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    #3;
    chk("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_mem_a", mem_req_a, 32'd0);
    chk("rst_ready", {29'b0, if_req_ready, ls_req_ready, mem_resp_ready}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Tie after reset goes to LS, then alternates IF, LS, IF.
    run(1, 1, 1, 32'h104, 32'h200, 1'b1, 4'b0011, 32'h1234, 32'h0, 0, 0, 0);
    run(1, 1, 0, 32'h104, 32'h204, 1'b0, 4'hF, 32'h0, 32'h11111111, 0, 0, 0);
    run(1, 1, 1, 32'h108, 32'h204, 1'b0, 4'hF, 32'h0, 32'h22222222, 4, 0, 0);
    run(1, 0, 0, 32'h108, 32'h0, 1'b0, 4'h0, 32'h0, 32'h33333333, 0, 0, 0);

    // Single fetch with two memory wait cycles.
    run(1, 0, 0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 2, 0);

    // Flush during ISSUE: request still issued, response drained.
    if_req_valid = 1'b1; if_req_a = 32'h300;
    #4;
    chk("fi_if_ready", {31'b0, if_req_ready}, 32'd1);
    tick();
    if_req_valid = 1'b0; flush = 1'b1; mem_req_ready = 1'b0;
    #4;
    chk("fi_valid0", {31'b0, mem_req_valid}, 32'd1);
    tick();
    flush = 1'b0; mem_req_ready = 1'b1;
    #4;
    chk("fi_valid1", {31'b0, mem_req_valid}, 32'd1);
    chk("fi_a", mem_req_a, 32'h300);
    tick();
    mem_req_ready = 1'b0;
    #4;
    chk("fi_drain_ready", {31'b0, mem_resp_ready}, 32'd1);
    chk("fi_if_resp0", {31'b0, if_resp_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
    #4;
    chk("fi_if_resp1", {31'b0, if_resp_valid}, 32'd0);
    chk("fi_drain_take", {31'b0, mem_resp_ready}, 32'd1);
    tick();
    mem_resp_valid = 1'b0;
    run(0, 1, 1, 32'h0, 32'h400, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 0, 0, 0);

    // Flush during WAIT of an LS load has no effect.
    run(0, 1, 1, 32'h0, 32'h404, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 0, 1, 1);

    // Flush in IDLE suppresses the fetch grant for that cycle only.
    if_req_valid = 1'b1; if_req_a = 32'h500; flush = 1'b1;
    #4;
    chk("fidle_no_grant", {31'b0, if_req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    run(1, 0, 0, 32'h500, 32'h0, 1'b0, 4'h0, 32'h0, 32'h50, 0, 0, 0);

    // Flush coinciding with the fetch response in WAIT: dropped, drained next cycle.
    fetch_to_wait(32'h700);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77; flush = 1'b1;
    #4;
    chk("fw_if_resp", {31'b0, if_resp_valid}, 32'd0);
    chk("fw_mem_ready", {31'b0, mem_resp_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #4;
    chk("fw_drain_resp", {31'b0, if_resp_valid}, 32'd0);
    chk("fw_drain_ready", {31'b0, mem_resp_ready}, 32'd1);
    tick();
    mem_resp_valid = 1'b0;
    run(0, 1, 1, 32'h0, 32'h408, 1'b0, 4'hF, 32'h0, 32'h12345678, 0, 0, 0);

    // Asynchronous reset in WAIT clears everything at once.
    fetch_to_wait(32'h800);
    #2;
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_a = 32'h600;
    #1;
    chk("ar_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("ar_mem_a", mem_req_a, 32'd0);
    chk("ar_ready", {29'b0, if_req_ready, ls_req_ready, mem_resp_ready}, 32'd0);
    chk("ar_resp", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    run(1, 0, 0, 32'h600, 32'h0, 1'b0, 4'h0, 32'h0, 32'h60, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single external memory port between instruction fetch (`if_*`) and the load/store exec unit (`ls_*`). It allows one transaction in flight and latches the granted request. Responses go back to whichever requester owns the transaction. The arbiter alternates grants round-robin when both requesters contend. On `flush`, an in-flight instruction-fetch transaction is completed on the bus and its response is dropped.

## Interface
- No parameters. Address and data are 32 bits. A request payload carries `a`[31:0], `we`[0], `be`[3:0] and `d`[31:0].
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low; clears all state immediately while low.
- `if_req` decoupled.in, payload as above: fetch request; `we`=0 is expected.
- `if_resp` decoupled.out [31:0]: fetch read data.
- `ls_req` decoupled.in, payload as above: load/store request from the mem exec unit.
- `ls_resp` decoupled.out [31:0]: load data, or a store acknowledge whose data is ignored.
- `mem_req` decoupled.out, payload as above: request to the external memory.
- `mem_resp` decoupled.in [31:0]: external memory response; exactly one response per accepted request, in order.
- `flush` in 1: pipeline flush. It kills any fetch-owned transaction at any stage. It never affects load/store transactions.

## Operation
- State machine:
  - IDLE: no transaction.
  - ISSUE: `mem_req.valid`=1 with the latched payload, waiting for `mem_req.ready`.
  - WAIT: request accepted, waiting for `mem_resp`.
  - DRAIN: killed fetch; the response is consumed and discarded.
- Registers: `state`, `owner` (IF/LS), `last` (IF/LS, the most recent grant), latched payload (69 bits), `killed`.
- IDLE arbitration (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not `last`.
  - The granted `*_req.ready`=1 that cycle, and the payload is latched.
  - Update `owner` and `last`, then go to ISSUE.
  - A fetch is not granted in a cycle where `flush`=1.
- `*_req.ready` is 0 in every state except IDLE.
- ISSUE:
  - `mem_req.data` is the latched payload and is held stable until `mem_req.ready`. `valid` is never withdrawn.
  - On handshake: go to WAIT, or to DRAIN if `killed`, or if `flush`=1 in that cycle with `owner`=IF.
  - `flush` with `owner`=IF while in ISSUE sets `killed`.
- WAIT:
  - The owner's `*_resp.valid` = `mem_resp.valid` and `*_resp.data` = `mem_resp.data`.
  - `mem_resp.ready` = the owner's `*_resp.ready`. The non-owner's `resp.valid`=0.
  - On the response handshake, return to IDLE.
  - `flush` with `owner`=IF: go to DRAIN immediately. `if_resp.valid` is forced to 0 in the flush cycle.
- DRAIN: `mem_resp.ready`=1, with no upstream valid. On `mem_resp.valid`, go to IDLE and clear `killed`.
- `flush` in IDLE, or with `owner`=LS, has no effect.

## Timing
- Reset values:
  - `state`=IDLE, `last`=IF (so the first tie goes to LS), `killed`=0, payload=0.
  - All outputs reset to 0: `if_req.ready`, `ls_req.ready`, `mem_req.valid`, `if_resp.valid`, `ls_resp.valid`, `mem_resp.ready`, and all data buses.
- Cycle numbering:
  - Upstream accept happens in cycle N (IDLE).
  - `mem_req.valid` is first high in N+1.
  - The response is forwarded combinationally in the same cycle `mem_resp.valid` is high (zero added latency).
  - The arbiter re-enters IDLE the cycle after the response handshake.
- Minimum occupancy is 3 cycles per transaction, with zero-wait memory. Next accept is possible no earlier than the cycle after the response handshake.
- Upstream requesters must hold `valid` and payload until `ready`. The arbiter never grants both in one cycle.
- If reset is asserted mid-transaction, the arbiter returns to IDLE asynchronously. Any outstanding external response after reset is the memory's responsibility (memory is reset together).
- `flush` coinciding with the `if_resp` handshake in WAIT: `if_resp.valid` is forced to 0. The `mem_resp` beat is consumed only through DRAIN, which accepts it next cycle if it is still valid.

## Test plan
- Single fetch, a=0x100, memory returns 0xDEADBEEF after 2 wait cycles: `if_resp` gets 0xDEADBEEF. Total 5 cycles from accept to IDLE; `ls_resp.valid` stays 0.
- Both request in cycle 0 after reset: LS is granted first (store a=0x200, be=4'b0011, d=0x1234), then IF. Next tie grants LS again; grants alternate LS, IF, LS, IF.
- `mem_req.ready` held low 4 cycles during ISSUE: `mem_req.data` stays constant and `valid` stays high throughout; `ls_req.ready` stays 0.
- `flush` during ISSUE of fetch a=0x300: the request is still issued, the response 0x55 is discarded, and `if_resp.valid` never rises. A following LS load returns its own data correctly.
- `flush` during WAIT of an LS load: no effect; `ls_resp` receives the data. A `flush` while `if_req.valid` in IDLE produces no fetch grant that cycle.
- Reset asserted (low) during WAIT: all outputs are 0 immediately and `state`=IDLE. After release, a new fetch completes normally.
